// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the single unified memory port between the instruction-fetch (I)
// and data-memory (D) pipeline stages. Only one access is in flight at a
// time. Each access ends when memory acknowledges it, or when a watchdog
// aborts it after TIMEOUT busy cycles. Stall and done strobes go back to
// the pipeline control.
//
// Build option:
//   ARB_RR_EN  when defined, a simultaneous I/D request is granted to the
//              stage that did not win the previous grant. When undefined,
//              D always wins and no last-owner state exists.
//
// Parameters:
//   TIMEOUT    busy cycles allowed before abort (1..255)
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   i_req      fetch request, held until i_done
//   d_req      data request, held until d_done
//   d_we       data store flag, captured at grant
//   mem_ack    memory finished the current access this cycle
//   mem_req    access in progress toward memory
//   mem_we     write enable toward memory (0 when idle)
//   mem_sel    address/data mux select (0 = I, 1 = D)
//   i_done     one-cycle pulse: fetch access finished or aborted
//   d_done     one-cycle pulse: data access finished or aborted
//   i_stall    i_req & ~i_done
//   d_stall    d_req & ~d_done
//   err        one-cycle pulse on watchdog abort

module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic d_we,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic mem_sel,
    output logic i_done,
    output logic d_done,
    output logic i_stall,
    output logic d_stall,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // The counter starts at 0 on the first busy cycle, so TIMEOUT-1 marks
    // the last busy cycle the watchdog allows.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       we_q, we_d;
    logic       grant_i, grant_d;
    logic       expired;
    logic       finish;

`ifdef ARB_RR_EN
    // last_q = 1 means D won the most recent grant.
    logic last_q, last_d;

    // On a tie, give the port to the stage that did not win last time.
    always_comb begin
        grant_d = d_req & (~i_req | ~last_q);
        grant_i = i_req & ~grant_d;
    end
`else
    always_comb begin
        grant_d = d_req;
        grant_i = i_req & ~d_req;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        mem_req = 1'b0;
        mem_we  = 1'b0;
        i_done  = 1'b0;
        d_done  = 1'b0;
        err     = 1'b0;
        expired = (cnt_q == CNT_LAST);
        finish  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                we_d  = 1'b0;
                if (grant_d) begin
                    state_d = BUSY_D;
                    sel_d   = 1'b1;
                    we_d    = d_we;
`ifdef ARB_RR_EN
                    last_d  = 1'b1;
`endif
                end else if (grant_i) begin
                    state_d = BUSY_I;
                    sel_d   = 1'b0;
                    we_d    = 1'b0;
`ifdef ARB_RR_EN
                    last_d  = 1'b0;
`endif
                end
            end

            BUSY_I, BUSY_D: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                // An ack on the expiry cycle wins, so that cycle counts
                // as a normal completion and does not raise err.
                finish  = mem_ack | expired;
                if (finish) begin
                    i_done  = (state_q == BUSY_I);
                    d_done  = (state_q == BUSY_D);
                    err     = ~mem_ack;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // mem_sel keeps its last value while idle, so the mux input stays
    // stable between accesses.
    assign mem_sel = sel_q;
    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

endmodule
